// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants, state/action enums and small address helpers for the
// instruction fetch stage.
//
// Contents:
//   TEXT_BASE   byte address of instruction word 0
//   IMEM_AW     instruction memory word-address width
//   NOP_INSTR   encoding inserted into IF/ID as a bubble (sll $0,$0,0)
//   TEXT_BYTES  size of the text segment in bytes
//   fetch_state_e  BOOT / RUN / HALT
//   fetch_act_e    per-edge action chosen by the PC priority logic
//   word_index()   PC word field -> instruction memory word address
//   in_text()      byte address lies inside the text segment
//
// Optional feature macro used by the stage: IF_FAULT_CHECK_EN
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
   localparam int          IMEM_AW    = 10;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] TEXT_BYTES = 32'd4 << IMEM_AW;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_e;

   // One action per clock edge; the IF/ID register and FSM key off this.
   typedef enum logic [2:0] {
      ACT_IDLE,
      ACT_HALT,
      ACT_FAULT,
      ACT_REDIRECT,
      ACT_STALL,
      ACT_ADVANCE
   } fetch_act_e;

   // TEXT_BASE has zero low bits, so subtracting only the word field of the
   // base from the word field of the PC gives the wrapped word offset.
   function automatic logic [IMEM_AW-1:0] word_index(input logic [IMEM_AW-1:0] pc_word);
      return pc_word - TEXT_BASE[IMEM_AW+1:2];
   endfunction

   // Unsigned compare after rebasing also rejects addresses below TEXT_BASE.
   function automatic logic in_text(input logic [31:0] byte_addr);
      return (byte_addr - TEXT_BASE) < TEXT_BYTES;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the instruction memory bus and the IF/ID pipeline register outputs.
//
// Signals:
//   imem_addr    word address to instruction memory
//   imem_data    instruction word, combinational from imem_addr
//   if_valid     IF/ID holds a live instruction
//   if_pc        byte PC of if_instr
//   if_pc_plus4  if_pc + 4
//   if_instr     registered instruction
//
// Modports:
//   master  fetch stage (drives address and IF/ID, receives memory data)
//   slave   memory / decode side
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
   import fetch_pkg::*;

   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_data;
   logic               if_valid;
   logic [31:0]        if_pc;
   logic [31:0]        if_pc_plus4;
   logic [31:0]        if_instr;

   modport master (
      output imem_addr,
      output if_valid,
      output if_pc,
      output if_pc_plus4,
      output if_instr,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      input  if_valid,
      input  if_pc,
      input  if_pc_plus4,
      input  if_instr,
      output imem_data
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register, next-PC mux and the per-edge priority decision
// (halt > [fault] > redirect > stall > advance).
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   active          fetch is not halted; when low the PC is frozen
//   halt_req        stop fetching
//   redirect_valid  load redirect_pc as next PC
//   redirect_pc     byte target of branch/jump/jr
//   stall           hold PC
//   pc_q            current fetch PC (byte address)
//   imem_addr       word address of pc_q within the text segment
//   act             action taken on the coming edge
//
// Macro IF_FAULT_CHECK_EN: misaligned or out-of-text redirect targets and an
// out-of-text sequential PC produce ACT_FAULT instead of being fetched.
// -----------------------------------------------------------------------------
module fetch_pc_reg
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               active,
   input  logic               halt_req,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               stall,
   output logic [31:0]        pc_q,
   output logic [IMEM_AW-1:0] imem_addr,
   output fetch_act_e         act
);

   logic [31:0] pc_d;

`ifdef IF_FAULT_CHECK_EN
   logic fault_hit;
`endif

   // Out-of-range addresses simply wrap onto the memory here.
   assign imem_addr = word_index(pc_q[IMEM_AW+1:2]);

   // Priority decision and next-PC selection. A frozen PC (halt, fault, stall,
   // idle) is the default; only redirect and advance move it.
   always_comb begin
      act  = ACT_IDLE;
      pc_d = pc_q;
`ifdef IF_FAULT_CHECK_EN
      // A redirect replaces the current PC, so only its target matters then.
      fault_hit = redirect_valid ? ((redirect_pc[1:0] != 2'b00) || !in_text(redirect_pc))
                                 : !in_text(pc_q);
`endif
      if (!active) begin
         act = ACT_IDLE;
      end else if (halt_req) begin
         act = ACT_HALT;
`ifdef IF_FAULT_CHECK_EN
      end else if (fault_hit) begin
         act = ACT_FAULT;
`endif
      end else if (redirect_valid) begin
         act  = ACT_REDIRECT;
         pc_d = redirect_pc & ~32'h0000_0003;
      end else if (stall) begin
         act = ACT_STALL;
      end else begin
         act  = ACT_ADVANCE;
         pc_d = pc_q + 32'd4;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= TEXT_BASE;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC (via fetch_pc_reg), drives the instruction memory
// word address, and registers the returned instruction into IF/ID. Handles
// sequential fetch, redirects, stalls, flushes and halt. No delay slot.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   stall           hold PC and IF/ID
//   flush           squash the instruction being captured into IF/ID
//   redirect_valid  load redirect_pc as next PC (one bubble follows)
//   redirect_pc     byte target of branch/jump/jr
//   halt_req        stop fetching until reset
//   bus             instruction_fetch_if.master: imem_addr/imem_data and
//                   if_valid/if_pc/if_pc_plus4/if_instr
//   halted          fetch is in HALT
//   fetch_fault     sticky fault flag
//
// Macro IF_FAULT_CHECK_EN: when defined, a misaligned or out-of-text redirect
// target or fetch PC sets fetch_fault and halts with a bubble. When undefined
// fetch_fault is tied low and addresses wrap.
// -----------------------------------------------------------------------------
module instruction_fetch
   import fetch_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   input  logic                       halt_req,
   instruction_fetch_if.master        bus,
   output logic                       halted,
   output logic                       fetch_fault
);

   fetch_state_e       state_q, state_d;
   logic               if_valid_q, if_valid_d;
   logic [31:0]        if_pc_q, if_pc_d;
   logic [31:0]        if_pc_plus4_q, if_pc_plus4_d;
   logic [31:0]        if_instr_q, if_instr_d;

   logic [31:0]        pc_q;
   logic [IMEM_AW-1:0] imem_addr;
   fetch_act_e         act;
   logic               bubble;

   fetch_pc_reg u_pc_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .active         (state_q != HALT),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .pc_q           (pc_q),
      .imem_addr      (imem_addr),
      .act            (act)
   );

   assign bus.imem_addr   = imem_addr;
   assign bus.if_valid    = if_valid_q;
   assign bus.if_pc       = if_pc_q;
   assign bus.if_pc_plus4 = if_pc_plus4_q;
   assign bus.if_instr    = if_instr_q;
   assign halted          = (state_q == HALT);

   // FSM next state and IF/ID update. A bubble clears valid and the
   // instruction but leaves if_pc/if_pc_plus4 at their last values. A flush
   // under stall still bubbles IF/ID even though the PC holds.
   always_comb begin
      state_d       = state_q;
      if_valid_d    = if_valid_q;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      if_instr_d    = if_instr_q;
      bubble        = 1'b0;

      case (act)
         ACT_HALT,
         ACT_FAULT: begin
            bubble  = 1'b1;
            state_d = HALT;
         end
         ACT_REDIRECT: begin
            bubble  = 1'b1;
            state_d = RUN;
         end
         ACT_STALL: begin
            bubble = flush;
         end
         ACT_ADVANCE: begin
            state_d = RUN;
            if (flush) begin
               bubble = 1'b1;
            end else begin
               if_valid_d    = 1'b1;
               if_pc_d       = pc_q;
               if_pc_plus4_d = pc_q + 32'd4;
               if_instr_d    = bus.imem_data;
            end
         end
         default: begin
         end
      endcase

      if (bubble) begin
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
      end
   end

   // State and IF/ID registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         if_valid_q    <= 1'b0;
         if_pc_q       <= 32'h0000_0000;
         if_pc_plus4_q <= 32'h0000_0000;
         if_instr_q    <= NOP_INSTR;
      end else begin
         state_q       <= state_d;
         if_valid_q    <= if_valid_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus4_q <= if_pc_plus4_d;
         if_instr_q    <= if_instr_d;
      end
   end

`ifdef IF_FAULT_CHECK_EN
   logic fault_q, fault_d;

   // Sticky until reset.
   always_comb begin
      fault_d = fault_q | (act == ACT_FAULT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed scoreboard bench for instruction_fetch. Each step drives the
// inputs for one clock edge, queues the IF/ID state expected after that edge,
// and pops/compares it once the edge has passed.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt_req = 1'b0;
   logic        halted;
   logic        fetch_fault;

   instruction_fetch_if bus ();

   logic [31:0] mem [0:1023];
   assign bus.imem_data = mem[bus.imem_addr];

   instruction_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .bus            (bus),
      .halted         (halted),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [9:0]  addr;
      logic        halted;
      logic        fault;
   } expect_t;

   expect_t sb[$];
   int testCount = 0;
   int failCount = 0;

   function automatic logic [31:0] word(input int i);
      return 32'h2011_0001 + 32'(i) * 32'h100;
   endfunction

   task automatic checkField(input string tag, input string name,
                             input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, name, observed, expected);
      end
   endtask

   // Drive one edge's inputs, queue what IF/ID should hold after it.
   task automatic applyStimulus(input logic rstnV, input logic stallV, input logic flushV,
                                input logic rvV, input logic [31:0] rpcV, input logic haltV,
                                input expect_t e);
      rst_n          = rstnV;
      stall          = stallV;
      flush          = flushV;
      redirect_valid = rvV;
      redirect_pc    = rpcV;
      halt_req       = haltV;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      expect_t e;
      logic [31:0] pc4;
      if (sb.size() == 0) begin
         testCount++;
         failCount++;
         $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
      end else begin
         e = sb.pop_front();
         pc4 = (e.pc == 32'h0) ? 32'h0 : e.pc + 32'd4;
         checkField(tag, "if_valid", {31'h0, bus.if_valid}, {31'h0, e.valid});
         checkField(tag, "if_instr", bus.if_instr, e.instr);
         checkField(tag, "if_pc", bus.if_pc, e.pc);
         checkField(tag, "if_pc_plus4", bus.if_pc_plus4, pc4);
         checkField(tag, "imem_addr", {22'h0, bus.imem_addr}, {22'h0, e.addr});
         checkField(tag, "halted", {31'h0, halted}, {31'h0, e.halted});
         checkField(tag, "fetch_fault", {31'h0, fetch_fault}, {31'h0, e.fault});
      end
   endtask

   task automatic step(input string tag, input logic rstnV, input logic stallV,
                       input logic flushV, input logic rvV, input logic [31:0] rpcV,
                       input logic haltV, input logic eValid, input logic [31:0] ePc,
                       input logic [31:0] eInstr, input int eAddr, input logic eHalted,
                       input logic eFault);
      expect_t e;
      e.valid  = eValid;
      e.pc     = ePc;
      e.instr  = eInstr;
      e.addr   = 10'(eAddr);
      e.halted = eHalted;
      e.fault  = eFault;
      applyStimulus(rstnV, stallV, flushV, rvV, rpcV, haltV, e);
      checkOutput(tag);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = word(i);

      //   tag              rst st fl rv rpc           hr  valid pc            instr       addr h f
      step("reset0",        0, 0, 0, 0, 32'h0,        0,  0, 32'h0,         32'h0,      0,   0, 0);
      step("reset1",        0, 1, 1, 1, 32'h3100,     0,  0, 32'h0,         32'h0,      0,   0, 0);
      step("boot",          1, 0, 0, 0, 32'h0,        0,  1, 32'h3000,      word(0),    1,   0, 0);
      step("redir3014",     1, 0, 0, 1, 32'h3014,     0,  0, 32'h3000,      32'h0,      5,   0, 0);
      step("tgt3014",       1, 0, 0, 0, 32'h0,        0,  1, 32'h3014,      word(5),    6,   0, 0);
      step("seq3018",       1, 0, 0, 0, 32'h0,        0,  1, 32'h3018,      word(6),    7,   0, 0);
      step("redir3008",     1, 0, 0, 1, 32'h3008,     0,  0, 32'h3018,      32'h0,      2,   0, 0);
      step("at3008",        1, 0, 0, 0, 32'h0,        0,  1, 32'h3008,      word(2),    3,   0, 0);
      step("stall0",        1, 1, 0, 0, 32'h0,        0,  1, 32'h3008,      word(2),    3,   0, 0);
      step("stall1",        1, 1, 0, 0, 32'h0,        0,  1, 32'h3008,      word(2),    3,   0, 0);
      step("stall2",        1, 1, 0, 0, 32'h0,        0,  1, 32'h3008,      word(2),    3,   0, 0);
      step("release",       1, 0, 0, 0, 32'h0,        0,  1, 32'h300C,      word(3),    4,   0, 0);
      step("flush",         1, 0, 1, 0, 32'h0,        0,  0, 32'h300C,      32'h0,      5,   0, 0);
      step("after_flush",   1, 0, 0, 0, 32'h0,        0,  1, 32'h3014,      word(5),    6,   0, 0);
      step("flush_stall",   1, 1, 1, 0, 32'h0,        0,  0, 32'h3014,      32'h0,      6,   0, 0);
      step("after_fs",      1, 0, 0, 0, 32'h0,        0,  1, 32'h3018,      word(6),    7,   0, 0);
      step("stall_redir",   1, 1, 0, 1, 32'h3040,     0,  0, 32'h3018,      32'h0,      16,  0, 0);
      step("tgt3040",       1, 0, 0, 0, 32'h0,        0,  1, 32'h3040,      word(16),   17,  0, 0);
`ifdef IF_FAULT_CHECK_EN
      step("misalign",      1, 0, 0, 1, 32'h3002,     0,  0, 32'h3040,      32'h0,      17,  1, 1);
      step("misalign_hold", 1, 0, 0, 0, 32'h0,        0,  0, 32'h3040,      32'h0,      17,  1, 1);
`else
      step("misalign",      1, 0, 0, 1, 32'h3002,     0,  0, 32'h3040,      32'h0,      0,   0, 0);
      step("misalign_tgt",  1, 0, 0, 0, 32'h0,        0,  1, 32'h3000,      word(0),    1,   0, 0);
`endif
      step("reset2",        0, 1, 0, 0, 32'h0,        0,  0, 32'h0,         32'h0,      0,   0, 0);
      step("boot2",         1, 0, 0, 0, 32'h0,        0,  1, 32'h3000,      word(0),    1,   0, 0);
      step("halt_redir",    1, 0, 0, 1, 32'h3100,     1,  0, 32'h3000,      32'h0,      1,   1, 0);
      step("halt_ign_rv",   1, 0, 0, 1, 32'h3200,     0,  0, 32'h3000,      32'h0,      1,   1, 0);
      step("halt_ign_st",   1, 1, 1, 0, 32'h0,        0,  0, 32'h3000,      32'h0,      1,   1, 0);
      step("halt_idle",     1, 0, 0, 0, 32'h0,        0,  0, 32'h3000,      32'h0,      1,   1, 0);
      step("reset_halt",    0, 1, 0, 0, 32'h0,        0,  0, 32'h0,         32'h0,      0,   0, 0);
      step("boot3",         1, 0, 0, 0, 32'h0,        0,  1, 32'h3000,      word(0),    1,   0, 0);
      step("redir_top",     1, 0, 0, 1, 32'h3FFC,     0,  0, 32'h3000,      32'h0,      1023,0, 0);
      step("last_word",     1, 0, 0, 0, 32'h0,        0,  1, 32'h3FFC,      word(1023), 0,   0, 0);
`ifdef IF_FAULT_CHECK_EN
      step("wrap",          1, 0, 0, 0, 32'h0,        0,  0, 32'h3FFC,      32'h0,      0,   1, 1);
`else
      step("wrap",          1, 0, 0, 0, 32'h0,        0,  1, 32'h4000,      word(0),    1,   0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
